// File: rtl/lsu_mem_stage_pkg.sv
// Shared opcodes, func3 codes and FSM state encoding for the LSU memory stage.
package lsu_mem_stage_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_reserved(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 >= 3'b011);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, replicated store data, load extract.
// LSU_MISALIGN_TRAP_EN makes misaligned halfword/word accesses raise misalign.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic [1:0]  lane;
  logic [15:0] shifted;

  always_comb begin
    lane      = 2'b00;
    be        = 4'b0000;
    wdata     = '0;
    misalign  = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        lane  = addr;
        be    = 4'b0001 << addr;
        wdata = {4{rs2_data[7:0]}};
      end
      F3_H, F3_HU: begin
        // Without the trap the odd byte offset is simply dropped.
        lane     = {addr[1], 1'b0};
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{rs2_data[15:0]}};
        misalign = TRAP && addr[0];
      end
      F3_W: begin
        be       = 4'b1111;
        wdata    = rs2_data;
        misalign = TRAP && (addr != 2'b00);
      end
      default: ;
    endcase

    shifted   = 16'(rdata >> {lane, 3'b000});
    load_data = '0;
    case (func3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted};
      F3_HU:   load_data = {16'd0, shifted};
      F3_W:    load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access / writeback stage: request/response handshake to data memory,
// watchdog abort, writeback triple. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic              wb_reg,
  input  logic [4:0]        rd_num,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       rs2_data,
  output logic              busy,
  output logic              done,
  output logic              wb_enable,
  output logic [4:0]        wb_rd_num,
  output logic [31:0]       wb_rd_data,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_reg;
  logic [2:0]       func3_reg;
  logic [1:0]       addr_lo_reg;
  logic             rd_write_reg;
  logic [CNT_W-1:0] wd_cnt_reg;

  logic [2:0]  al_func3;
  logic [1:0]  al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misalign;
  logic        is_load;
  logic        is_store;
  logic        f3_bad;
  logic        timeout_hit;

  // In IDLE the aligner sees live operands; afterwards the latched copies.
  always_comb begin
    al_func3    = (state_reg == S_IDLE) ? func3 : func3_reg;
    al_addr     = (state_reg == S_IDLE) ? alu_out[1:0] : addr_lo_reg;
    is_load     = (opcode == OPC_LOAD);
    is_store    = (opcode == OPC_STORE);
    f3_bad      = f3_reserved(is_store, func3);
    timeout_hit = (TIMEOUT != 0) && (wd_cnt_reg == CNT_W'(TIMEOUT - 1));
  end

  lsu_align u_align (
    .func3     (al_func3),
    .addr      (al_addr),
    .rs2_data  (rs2_data),
    .rdata     (dmem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load),
    .misalign  (al_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      func3_reg    <= '0;
      addr_lo_reg  <= '0;
      rd_write_reg <= 1'b0;
      wd_cnt_reg   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wb_enable    <= 1'b0;
      wb_rd_num    <= '0;
      wb_rd_data   <= '0;
      bus_err      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
    end else begin
      done      <= 1'b0;
      wb_enable <= 1'b0;
      bus_err   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            func3_reg    <= func3;
            addr_lo_reg  <= alu_out[1:0];
            rd_write_reg <= wb_reg && (rd_num != 5'd0);
            wb_rd_num    <= rd_num;
            wd_cnt_reg   <= '0;
            busy         <= 1'b1;
            if (!(is_load || is_store)) begin
              state_reg  <= S_WB;
              done       <= 1'b1;
              wb_enable  <= wb_reg && (rd_num != 5'd0);
              wb_rd_data <= alu_out;
            end else if (f3_bad || al_misalign) begin
              state_reg  <= S_WB;
              done       <= 1'b1;
              bus_err    <= 1'b1;
              wb_rd_data <= '0;
            end else begin
              state_reg  <= S_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
              dmem_be    <= al_be;
              dmem_wdata <= is_store ? al_wdata : '0;
              wb_rd_data <= alu_out;
            end
          end
        end
        S_REQ: begin
          // An acceptance in the final watchdog cycle still completes normally.
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              state_reg <= S_WB;
              done      <= 1'b1;
            end else begin
              state_reg  <= S_RESP;
              wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
            end
          end else if (timeout_hit) begin
            state_reg  <= S_WB;
            dmem_req   <= 1'b0;
            done       <= 1'b1;
            bus_err    <= 1'b1;
            wb_rd_data <= '0;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (dmem_rvalid) begin
            state_reg  <= S_WB;
            done       <= 1'b1;
            wb_enable  <= rd_write_reg;
            wb_rd_data <= al_load;
          end else if (timeout_hit) begin
            state_reg  <= S_WB;
            done       <= 1'b1;
            bus_err    <= 1'b1;
            wb_rd_data <= '0;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
          end
        end
        S_WB: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access/writeback stage of the 3-stage core; sits directly downstream of decode_execute.
- Consumes opcode, func3, rd info, ALU result and rs2 from decode_execute.
- Runs a multi-cycle request/response handshake to data memory for loads and stores.
- Returns a writeback triple to regfile and a one-cycle done pulse to the controller.

Parameters:
- TIMEOUT, 16: max cycles waiting in REQ or RESP before abort with bus_err; 0 disables the watchdog.
- ADDR_W, 32: data-memory address width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: operands valid; sampled only in IDLE.
- opcode  in  7  instruction opcode.
- func3  in  3  access size/sign.
- wb_reg  in  1  instruction writes rd.
- rd_num  in  5  destination register.
- alu_out  in  32  effective address (mem ops) or result (others).
- rs2_data  in  32  store data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse to controller.
- wb_enable  out  1  regfile write strobe.
- wb_rd_num  out  5  regfile write index.
- wb_rd_data  out  32  regfile write data.
- bus_err  out  1  valid with done; access aborted.
- dmem_req  out  1  request valid; held until accepted.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data word.

Behaviour:
- Reset: state IDLE; all outputs 0; latched operands and watchdog counter cleared.
- Reset is honoured in any state, including mid-transaction; dmem_req drops at that edge.
- States:
  - IDLE: on start, latch all inputs. LOAD (7'b0000011) or STORE (7'b0100011) -> REQ; any other opcode -> WB.
  - REQ: dmem_req=1 with stable addr/we/be/wdata. On dmem_ready: store -> WB, load -> RESP.
  - RESP: wait for dmem_rvalid; capture dmem_rdata; -> WB.
  - WB: done=1 for exactly one cycle; wb_enable/rd_num/rd_data valid in the same cycle; -> IDLE.
- Latency (cycles after the start cycle):
  - Non-memory op: done at +1.
  - Store with ready in the first REQ cycle: done at +2.
  - Load with ready at +1 and rvalid at +2: done at +3.
- Byte enables / store data:
  - SB: be = 1<<addr[1:0]; byte replicated x4.
  - SH: be = 4'b0011 or 4'b1100 by addr[1]; half replicated x2.
  - SW: be = 4'b1111.
  - Loads drive be with the same lane rules.
- Load extract: select lane by addr[1:0]. LB/LH sign-extend; LBU (100)/LHU (101) zero-extend; LW passes the word.
- Writeback: wb_enable = wb_reg & (rd_num != 0) & ~bus_err, and never for stores.
- Ignored inputs: dmem_rvalid outside RESP; dmem_ready outside REQ; start while busy.
- Watchdog: counter clears on entering REQ and increments each cycle in REQ/RESP. On reaching TIMEOUT (when TIMEOUT != 0): -> WB with bus_err=1, wb_enable=0, dmem_req dropped.
- Reserved func3 on load/store (011, 110, 111 loads; >=011 stores): no bus access; -> WB with bus_err=1.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]=1 or word with addr[1:0]!=0 skips REQ and goes to WB with bus_err=1 and no writeback.
- Undefined: the access proceeds using addr[1:0] forced to lane-legal values. Halfword uses addr[1] only; word ignores addr[1:0]. bus_err is never set for alignment.

Decomposition:
- Shared header param_lsu.vh:
  - OPC_LOAD, OPC_STORE.
  - F3_B/H/W/BU/HU.
  - State encodings (S_IDLE, S_REQ, S_RESP, S_WB, 2-bit).
- One combinational sub-module lsu_align:
  - Inputs: func3, addr[1:0], rs2_data, rdata.
  - Outputs: be, wdata, load result, misalign flag.
- The FSM, latches and watchdog stay in lsu_mem_stage.

Test Plan:
- ALU op: opcode 7'b0110011, rd=5, alu_out=0x1234 -> done at +1, wb_enable=1, wb_rd_num=5, wb_rd_data=0x1234, dmem_req never high.
- SB: addr 0x103, rs2=0xAB, ready after 3 wait cycles -> dmem_addr=0x100, be=4'b1000, wdata=0xABABABAB held stable throughout; done with wb_enable=0.
- LB/LBU: addr 0x202, rdata=0x00F00000 -> LB gives wb_rd_data=0xFFFFFFF0; LBU gives 0x000000F0.
- LW with rd=0 -> done=1, wb_enable=0.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> dmem_req drops after 4 cycles; done=1, bus_err=1.
- Reset in RESP, then a late rvalid -> IDLE, no done, no write. LH at 0x101: with LSU_MISALIGN_TRAP_EN gives bus_err=1 and no request; without it gives a request at 0x100 with be=4'b0011.
